// File: rtl/orientation_controller_if.sv
// Signal bundle between the orientation controller and its three neighbours:
// the ultrasound location block, the robot motion link and the math engine.
interface orientation_controller_if;
  logic        start;
  logic        loc_request;
  logic        loc_valid;
  logic [11:0] loc_r_theta;
  logic        move_request;
  logic        move_done;
  logic        math_enable;
  logic        math_done;
  logic [4:0]  math_orientation;
  logic [11:0] r_theta_original;
  logic [11:0] r_theta_final;
  logic [4:0]  orientation;
  logic        orientation_valid;
  logic        busy;
  logic        error;
  logic [1:0]  error_code;

  modport master (
    output start, loc_valid, loc_r_theta, move_done, math_done, math_orientation,
    input  loc_request, move_request, math_enable, r_theta_original, r_theta_final,
           orientation, orientation_valid, busy, error, error_code
  );

  modport slave (
    input  start, loc_valid, loc_r_theta, move_done, math_done, math_orientation,
    output loc_request, move_request, math_enable, r_theta_original, r_theta_final,
           orientation, orientation_valid, busy, error, error_code
  );
endinterface

// File: rtl/orientation_controller.sv
// Sequences one heading measurement: fix, drive forward, fix again, run the
// orientation math engine on the pair and publish the 5-bit heading.
//
// state        | meaning
// S_IDLE       | waiting for start
// S_REQ_ORIG   | pulse loc_request for the first fix
// S_WAIT_ORIG  | waiting for the first fix
// S_MOVE       | move_request held, waiting for move_done
// S_REQ_FINAL  | pulse loc_request for the second fix
// S_WAIT_FINAL | waiting for the second fix
// S_CHECK      | reject the pair if the robot did not move
// S_MATH       | pulse math_enable
// S_WAIT_LO    | waiting for the engine's stale done to drop
// S_WAIT_HI    | waiting for the engine's fresh done
// S_REPORT     | pulse orientation_valid
// S_FAIL       | pulse error with error_code
module orientation_controller #(
  parameter logic [26:0] TIMEOUT_CYCLES = 27'd67_500_000,
  parameter logic [1:0]  MAX_RETRIES    = 2'd2,
  parameter logic [7:0]  MIN_MOVE_R     = 8'd4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  orientation_controller_if.slave   bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_ORIG, S_WAIT_ORIG, S_MOVE, S_REQ_FINAL, S_WAIT_FINAL,
    S_CHECK, S_MATH, S_WAIT_LO, S_WAIT_HI, S_REPORT, S_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [26:0] timer_q, timer_d;
  logic [1:0]  retry_q, retry_d;
  logic [11:0] r_orig_q, r_orig_d;
  logic [11:0] r_final_q, r_final_d;
  logic [4:0]  orientation_q, orientation_d;
  logic [1:0]  error_code_q, error_code_d;
  logic        loc_request_q, loc_request_d;
  logic        move_request_q, move_request_d;
  logic        math_enable_q, math_enable_d;
  logic        orientation_valid_q, orientation_valid_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;

  logic        timeout;
  logic        fix_ok;
  logic        fix_bad;
  logic [7:0]  r_diff;
  logic [1:0]  code;

  // Next-state, datapath latches and registered-output decode.
  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    r_orig_d      = r_orig_q;
    r_final_d     = r_final_q;
    orientation_d = orientation_q;
    code          = 2'd0;

    timeout = (timer_q == TIMEOUT_CYCLES - 27'd1);
    // A valid fix takes priority over a timeout landing in the same cycle.
    fix_ok  = bus.loc_valid && (bus.loc_r_theta[7:0] != 8'd0);
    fix_bad = (bus.loc_valid && (bus.loc_r_theta[7:0] == 8'd0)) || (!bus.loc_valid && timeout);
    r_diff  = (r_final_q[7:0] >= r_orig_q[7:0]) ? (r_final_q[7:0] - r_orig_q[7:0])
                                                : (r_orig_q[7:0] - r_final_q[7:0]);

    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_REQ_ORIG;
        retry_d = 2'd0;
      end
      S_REQ_ORIG:  state_d = S_WAIT_ORIG;
      S_WAIT_ORIG: begin
        if (fix_ok) begin
          r_orig_d = bus.loc_r_theta;
          state_d  = S_MOVE;
        end else if (fix_bad) begin
          if (retry_q < MAX_RETRIES) begin
            retry_d = retry_q + 2'd1;
            state_d = S_REQ_ORIG;
          end else begin
            state_d = S_FAIL;
            code    = 2'd0;
          end
        end
      end
      S_MOVE: begin
        if (bus.move_done) state_d = S_REQ_FINAL;
        else if (timeout) begin
          state_d = S_FAIL;
          code    = 2'd1;
        end
      end
      S_REQ_FINAL:  state_d = S_WAIT_FINAL;
      S_WAIT_FINAL: begin
        if (fix_ok) begin
          r_final_d = bus.loc_r_theta;
          state_d   = S_CHECK;
        end else if (fix_bad) begin
          if (retry_q < MAX_RETRIES) begin
            retry_d = retry_q + 2'd1;
            state_d = S_REQ_FINAL;
          end else begin
            state_d = S_FAIL;
            code    = 2'd0;
          end
        end
      end
      S_CHECK: begin
        if ((r_orig_q[11:8] == r_final_q[11:8]) && (r_diff < MIN_MOVE_R)) begin
          state_d = S_FAIL;
          code    = 2'd3;
        end else begin
          state_d = S_MATH;
        end
      end
      S_MATH: state_d = S_WAIT_LO;
      // The engine's done is still high from the previous run; see it drop first.
      S_WAIT_LO: begin
        if (!bus.math_done) state_d = S_WAIT_HI;
        else if (timeout) begin
          state_d = S_FAIL;
          code    = 2'd2;
        end
      end
      S_WAIT_HI: begin
        if (bus.math_done) begin
          orientation_d = (bus.math_orientation >= 5'd24) ? (bus.math_orientation - 5'd24)
                                                          : bus.math_orientation;
          state_d = S_REPORT;
        end else if (timeout) begin
          state_d = S_FAIL;
          code    = 2'd2;
        end
      end
      S_REPORT: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // The final fix gets a fresh retry budget.
    if ((state_q == S_WAIT_ORIG) && (state_d != S_WAIT_ORIG) && (state_d != S_REQ_ORIG))
      retry_d = 2'd0;

    if (state_d != state_q)  timer_d = 27'd0;
    else if (timer_q != '1)  timer_d = timer_q + 27'd1;
    else                     timer_d = timer_q;

    loc_request_d       = (state_d == S_REQ_ORIG) || (state_d == S_REQ_FINAL);
    move_request_d      = (state_d == S_MOVE);
    math_enable_d       = (state_d == S_MATH);
    orientation_valid_d = (state_d == S_REPORT);
    busy_d              = (state_d != S_IDLE);
    error_d             = (state_d == S_FAIL);
    error_code_d        = (state_d == S_FAIL) ? code : 2'd0;
  end

  // State, counters and registered outputs; reset drops everything at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q             <= S_IDLE;
      timer_q             <= 27'd0;
      retry_q             <= 2'd0;
      r_orig_q            <= 12'd0;
      r_final_q           <= 12'd0;
      orientation_q       <= 5'd0;
      error_code_q        <= 2'd0;
      loc_request_q       <= 1'b0;
      move_request_q      <= 1'b0;
      math_enable_q       <= 1'b0;
      orientation_valid_q <= 1'b0;
      busy_q              <= 1'b0;
      error_q             <= 1'b0;
    end else begin
      state_q             <= state_d;
      timer_q             <= timer_d;
      retry_q             <= retry_d;
      r_orig_q            <= r_orig_d;
      r_final_q           <= r_final_d;
      orientation_q       <= orientation_d;
      error_code_q        <= error_code_d;
      loc_request_q       <= loc_request_d;
      move_request_q      <= move_request_d;
      math_enable_q       <= math_enable_d;
      orientation_valid_q <= orientation_valid_d;
      busy_q              <= busy_d;
      error_q             <= error_d;
    end
  end

  assign bus.loc_request       = loc_request_q;
  assign bus.move_request      = move_request_q;
  assign bus.math_enable       = math_enable_q;
  assign bus.r_theta_original  = r_orig_q;
  assign bus.r_theta_final     = r_final_q;
  assign bus.orientation       = orientation_q;
  assign bus.orientation_valid = orientation_valid_q;
  assign bus.busy              = busy_q;
  assign bus.error             = error_q;
  assign bus.error_code        = error_code_q;

endmodule

// File: tb/tb_orientation_controller.sv
// Bench for orientation_controller: scripted location/motion/engine responders,
// a measurement-level reference model, directed cases then randomized runs.
module tb_orientation_controller;
  localparam int TO = 100;
  localparam int MAXR = 2;

  logic clock;
  logic reset_n;
  orientation_controller_if bus();

  orientation_controller #(.TIMEOUT_CYCLES(27'd100), .MAX_RETRIES(2'd2), .MIN_MOVE_R(8'd4)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [11:0] loc_script [8];
  int          loc_len = 0;
  int          move_delay = 0;
  int          math_mode = 0;   // 0 normal, 1 done stuck high, 2 done never rises
  int          math_delay = 0;
  logic [4:0]  math_val = 5'd0;
  logic [4:0]  exp_orient = 5'd0;
  logic [11:0] exp_fx0, exp_fx1;
  int          start_cyc = 0;

  int n_req = 0, n_men = 0, n_ov = 0, n_err = 0, n_drop = 0, mr_bad = 0;
  int err_cyc = 0, mr_cyc = 0, ov_cyc = 0;
  logic [1:0] last_code = 2'd0;
  logic mr_prev = 1'b0;

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  // Pulse monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clock);
    if (bus.loc_request === 1'b1) n_req++;
    if (bus.math_enable === 1'b1) n_men++;
    if (bus.orientation_valid === 1'b1) begin n_ov++; ov_cyc = cyc; end
    if (bus.error === 1'b1) begin n_err++; last_code = bus.error_code; err_cyc = cyc; end
    if ((bus.move_request === 1'b1) && !mr_prev) mr_cyc = cyc;
    mr_prev = (bus.move_request === 1'b1);
  end

  // Location block: answers each request one cycle later from the script.
  initial begin : loc_resp
    int idx;
    idx = 0;
    bus.loc_valid = 1'b0;
    bus.loc_r_theta = 12'd0;
    forever begin
      if (bus.busy !== 1'b1) idx = 0;
      if (bus.loc_request === 1'b1) begin
        @(negedge clock);
        if (idx < loc_len) begin
          bus.loc_valid = 1'b1;
          bus.loc_r_theta = loc_script[idx];
          idx++;
        end
        @(negedge clock);
        bus.loc_valid = 1'b0;
      end else begin
        @(negedge clock);
      end
    end
  end

  // Motion link: move_done after move_delay cycles (never if negative).
  initial begin
    bus.move_done = 1'b0;
    forever begin
      @(negedge clock);
      if ((bus.move_request === 1'b1) && (move_delay >= 0)) begin
        repeat (move_delay) @(negedge clock);
        bus.move_done = 1'b1;
        @(negedge clock);
        bus.move_done = 1'b0;
        n_drop++;
        if (bus.move_request !== 1'b0) mr_bad++;
      end
    end
  end

  // Math engine: sticky done, drops on enable, rises with the new result.
  initial begin
    bus.math_done = 1'b0;
    bus.math_orientation = 5'd0;
    forever begin
      @(negedge clock);
      if (bus.math_enable === 1'b1) begin
        if (math_mode != 1) bus.math_done = 1'b0;
        @(negedge clock);
        @(negedge clock);
        if (math_mode == 0) begin
          repeat (math_delay) @(negedge clock);
          bus.math_orientation = math_val;
          bus.math_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Outcome of a whole measurement from the scripted responder behaviour.
  task automatic model(output int err, output int nreq, output int nmove, output logic [4:0] orient);
    logic [11:0] fx [2];
    int p, d;
    bit ok;
    err = -1; nreq = 0; nmove = 0; p = 0; orient = exp_orient;
    fx[0] = 12'd0; fx[1] = 12'd0;
    for (int f = 0; f < 2 && err < 0; f++) begin
      ok = 0;
      for (int a = 0; a <= MAXR && !ok; a++) begin
        nreq++;
        if (p < loc_len) begin
          if (loc_script[p][7:0] != 8'd0) begin ok = 1; fx[f] = loc_script[p]; end
          p++;
        end
      end
      if (!ok) err = 0;
      else if (f == 0) begin
        if (move_delay < 0) err = 1; else nmove = 1;
      end
    end
    if (err < 0) begin
      d = int'(fx[0][7:0]) - int'(fx[1][7:0]);
      if (d < 0) d = -d;
      if ((fx[0][11:8] == fx[1][11:8]) && (d < 4)) err = 3;
      else if (math_mode != 0) err = 2;
      else orient = (math_val >= 5'd24) ? math_val - 5'd24 : math_val;
    end
    exp_fx0 = fx[0];
    exp_fx1 = fx[1];
  endtask

  task automatic measure(input string tag);
    int err, nreq, nmove, r0, ov0, e0, m0, d0, b0;
    logic [4:0] orient;
    bit done;
    model(err, nreq, nmove, orient);
    @(negedge clock);
    r0 = n_req; ov0 = n_ov; e0 = n_err; m0 = n_men; d0 = n_drop; b0 = mr_bad;
    bus.start = 1'b1;
    start_cyc = cyc;
    @(negedge clock);
    bus.start = 1'b0;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clock);
      if ((n_ov != ov0) || (n_err != e0)) done = 1;
    end
    repeat (2) @(negedge clock);
    chk({tag, ":finished"}, 32'(done), 32'd1);
    chk({tag, ":loc_requests"}, 32'(n_req - r0), 32'(nreq));
    chk({tag, ":valid_pulses"}, 32'(n_ov - ov0), (err < 0) ? 32'd1 : 32'd0);
    chk({tag, ":error_pulses"}, 32'(n_err - e0), (err >= 0) ? 32'd1 : 32'd0);
    if (err >= 0) chk({tag, ":error_code"}, 32'(last_code), 32'(err));
    chk({tag, ":orientation"}, 32'(bus.orientation), 32'(orient));
    chk({tag, ":math_enables"}, 32'(n_men - m0), ((err < 0) || (err == 2)) ? 32'd1 : 32'd0);
    chk({tag, ":move_dones"}, 32'(n_drop - d0), 32'(nmove));
    chk({tag, ":move_req_drop"}, 32'(mr_bad - b0), 32'd0);
    chk({tag, ":busy_idle"}, 32'(bus.busy), 32'd0);
    if (err != 0) chk({tag, ":r_theta_original"}, 32'(bus.r_theta_original), 32'(exp_fx0));
    if ((err < 0) || (err >= 2)) chk({tag, ":r_theta_final"}, 32'(bus.r_theta_final), 32'(exp_fx1));
    exp_orient = orient;
  endtask

  initial begin
    bus.start = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset:ctl", 32'({bus.loc_request, bus.move_request, bus.math_enable, bus.orientation_valid,
                          bus.busy, bus.error, bus.error_code, bus.orientation}), 32'd0);
    chk("reset:fixes", 32'({bus.r_theta_original, bus.r_theta_final}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    loc_script[0] = 12'h20A; loc_script[1] = 12'h31E; loc_len = 2;
    move_delay = 50; math_val = 5'd7; math_delay = 3; math_mode = 0;
    measure("happy");

    // done is still high carrying 7; the new result 5 arrives later.
    move_delay = 2; math_val = 5'd5; math_delay = 5;
    measure("stale_done");

    move_delay = 0; math_val = 5'd26; math_delay = 0;
    measure("zero_wait");
    chk("zero_wait:latency", 32'(ov_cyc - start_cyc), 32'd10);

    loc_script[0] = 12'h500; loc_script[1] = 12'h500; loc_script[2] = 12'h50A; loc_script[3] = 12'h61E;
    loc_len = 4; move_delay = 3; math_val = 5'd9; math_delay = 2;
    measure("retry_ok");

    loc_script[0] = 12'h500; loc_script[1] = 12'h500; loc_script[2] = 12'h500; loc_len = 3;
    measure("retry_exhausted");

    loc_len = 0;
    measure("loc_timeout");

    loc_script[0] = 12'h20A; loc_script[1] = 12'h31E; loc_len = 2; move_delay = -1;
    measure("move_timeout");
    chk("move_timeout:cycles", 32'(err_cyc - mr_cyc), 32'(TO));

    loc_script[0] = 12'h30A; loc_script[1] = 12'h30C; move_delay = 4;
    measure("no_move");
    loc_script[1] = 12'h30E; math_val = 5'd23;
    measure("move_exact_min");
    loc_script[1] = 12'h40B; math_val = 5'd31;
    measure("theta_changed");

    math_mode = 1;
    measure("math_stuck_high");
    math_mode = 2;
    measure("math_never_high");
    math_mode = 0;

    loc_script[0] = 12'h20A; loc_script[1] = 12'h31E; loc_len = 2; move_delay = -1;
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 0; i < 50 && (bus.move_request !== 1'b1); i++) @(negedge clock);
    chk("reset_mid_move:in_move", 32'(bus.move_request), 32'd1);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_mid_move:move_request", 32'(bus.move_request), 32'd0);
    chk("reset_mid_move:outs", 32'({bus.busy, bus.orientation, bus.r_theta_original}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    exp_orient = 5'd0;
    move_delay = 4; math_val = 5'd12; math_delay = 1;
    measure("after_reset");

    for (int k = 0; k < 24; k++) begin
      logic [3:0] th;
      int rr, pr;
      loc_len = int'($urandom_range(5, 2));
      for (int j = 0; j < loc_len; j++) begin
        th = 4'($urandom_range(15, 0));
        rr = ($urandom_range(5, 0) == 0) ? 0 : int'($urandom_range(255, 1));
        if ((j > 0) && ($urandom_range(1, 0) == 1)) begin
          th = loc_script[j-1][11:8];
          pr = int'(loc_script[j-1][7:0]);
          rr = pr + int'($urandom_range(10, 0)) - 5;
          if (rr < 0) rr = 0;
          if (rr > 255) rr = 255;
        end
        loc_script[j] = {th, 8'(rr)};
      end
      move_delay = ($urandom_range(15, 0) == 0) ? -1 : int'($urandom_range(40, 0));
      math_delay = int'($urandom_range(20, 0));
      math_val = 5'($urandom_range(31, 0));
      measure($sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
